// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl
// Frame controller placed right after the byte serializer. It accepts a byte,
// loads the serializer, paces one bit every CLKS_PER_BIT clocks, and puts
// start / data (LSB first) / optional parity / stop onto TX_OUT.
//
// Ports
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   P_DataIn     : byte to send, captured by the serializer on Ser_Load
//   Data_Valid   : send request, only looked at while idle
//   Par_EN       : append a parity bit (latched at accept)
//   Par_Type     : 0 even, 1 odd (latched at accept)
//   Ser_Data     : current serializer output bit
//   Ser_Load     : one-cycle strobe, serializer captures P_DataIn
//   Ser_Shift    : one-cycle strobe, serializer advances one bit
//   TX_OUT       : serial line, idle high
//   Busy         : frame in progress
//   Frame_Done   : one-cycle pulse in the last cycle of the stop bit
module uart_tx_frame_ctrl #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] P_DataIn,
  input  logic             Data_Valid,
  input  logic             Par_EN,
  input  logic             Par_Type,
  input  logic             Ser_Data,
  output logic             Ser_Load,
  output logic             Ser_Shift,
  output logic             TX_OUT,
  output logic             Busy,
  output logic             Frame_Done
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH) + 1;

  localparam logic [PW-1:0] PS_LAST  = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PS_DONE  = PW'(CLKS_PER_BIT - 2);
  localparam logic [PW-1:0] PS_SHIFT = PW'((CLKS_PER_BIT > 2) ? CLKS_PER_BIT - 3 : 0);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_PEN  = BW'(WIDTH - 2);
  localparam logic [BW-1:0] BIT_SAT  = BW'(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_prescale;
  logic [BW-1:0]   r_bitcnt;
  logic            r_par_en;
  logic            r_par_bit;

  logic            w_bit_end;
  logic            w_shift_nxt;

  assign w_bit_end = (r_prescale == PS_LAST);

  // TX_OUT is a register that samples Ser_Data on the bit boundary, so the
  // serializer must already show the next bit at that edge. The shift strobe
  // is therefore registered one cycle early: it is high in the next-to-last
  // cycle of the bit and the serializer's new bit is settled during the last
  // cycle. With CLKS_PER_BIT = 2 that cycle is the first cycle of the bit,
  // so the strobe is set on the preceding boundary (including START->DATA).
  always_comb begin
    w_shift_nxt = 1'b0;
    if (CLKS_PER_BIT == 2)
      w_shift_nxt = ((r_state == S_START) && w_bit_end) ||
                    ((r_state == S_DATA) && w_bit_end && (r_bitcnt < BIT_PEN));
    else
      w_shift_nxt = (r_state == S_DATA) && (r_prescale == PS_SHIFT) &&
                    (r_bitcnt < BIT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_prescale <= '0;
      r_bitcnt   <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      TX_OUT     <= 1'b1;
      Busy       <= 1'b0;
      Ser_Load   <= 1'b0;
      Ser_Shift  <= 1'b0;
      Frame_Done <= 1'b0;
    end else begin
      Ser_Load   <= 1'b0;
      Ser_Shift  <= w_shift_nxt;
      Frame_Done <= (r_state == S_STOP) && (r_prescale == PS_DONE);
      r_prescale <= (r_state == S_IDLE || w_bit_end) ? '0 : r_prescale + 1'b1;

      case (r_state)
        S_IDLE: begin
          TX_OUT   <= 1'b1;
          Busy     <= 1'b0;
          r_bitcnt <= '0;
          if (Data_Valid) begin
            r_state   <= S_START;
            Ser_Load  <= 1'b1;
            TX_OUT    <= 1'b0;
            Busy      <= 1'b1;
            r_par_en  <= Par_EN;
            r_par_bit <= (^P_DataIn) ^ Par_Type;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
            TX_OUT  <= Ser_Data;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bitcnt == BIT_LAST) begin
              r_bitcnt <= BIT_SAT;
              if (r_par_en) begin
                r_state <= S_PARITY;
                TX_OUT  <= r_par_bit;
              end else begin
                r_state <= S_STOP;
                TX_OUT  <= 1'b1;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
              TX_OUT   <= Ser_Data;
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            TX_OUT  <= 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_state <= S_IDLE;
            Busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          TX_OUT  <= 1'b1;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Scoreboard bench: stimulus pushes the expected frame, a monitor per DUT
// pops it when Busy rises and checks the whole frame cycle by cycle.
// DUT a uses CLKS_PER_BIT = 4, DUT b uses the minimum of 2.
module tb_uart_tx_frame_ctrl;

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       pbit;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] din_a = 8'h00, din_b = 8'h00;
  logic dv_a = 1'b0, dv_b = 1'b0;
  logic pen_a = 1'b0, pen_b = 1'b0;
  logic pty_a = 1'b0, pty_b = 1'b0;
  logic sd_a, sd_b;
  logic load_a, shift_a, tx_a, busy_a, done_a;
  logic load_b, shift_b, tx_b, busy_b, done_b;
  logic [7:0] sreg_a, sreg_b;

  uart_tx_frame_ctrl #(.WIDTH(8), .CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .rst(rst), .P_DataIn(din_a), .Data_Valid(dv_a), .Par_EN(pen_a),
    .Par_Type(pty_a), .Ser_Data(sd_a), .Ser_Load(load_a), .Ser_Shift(shift_a),
    .TX_OUT(tx_a), .Busy(busy_a), .Frame_Done(done_a));

  uart_tx_frame_ctrl #(.WIDTH(8), .CLKS_PER_BIT(2)) dut_b (
    .clk(clk), .rst(rst), .P_DataIn(din_b), .Data_Valid(dv_b), .Par_EN(pen_b),
    .Par_Type(pty_b), .Ser_Data(sd_b), .Ser_Load(load_b), .Ser_Shift(shift_b),
    .TX_OUT(tx_b), .Busy(busy_b), .Frame_Done(done_b));

  // Serializer models: load captures the byte, shift moves toward the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_a <= 8'h00;
      sreg_b <= 8'h00;
    end else begin
      if (load_a) sreg_a <= din_a;
      else if (shift_a) sreg_a <= {1'b0, sreg_a[7:1]};
      if (load_b) sreg_b <= din_b;
      else if (shift_b) sreg_b <= {1'b0, sreg_b[7:1]};
    end
  end
  assign sd_a = sreg_a[0];
  assign sd_b = sreg_b[0];

  exp_t q[2][$];
  int   fdone[2];
  int   lastgap[2];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] sig(input int w);
    // {load, shift, tx, busy, done}
    return (w == 0) ? {load_a, shift_a, tx_a, busy_a, done_a}
                    : {load_b, shift_b, tx_b, busy_b, done_b};
  endfunction

  task automatic monitor(input int w);
    int cpb, len, nb, gap, txerr, loads, shifts, dones, dpos, busyerr, overlap, b;
    bit aborted;
    logic [4:0] s;
    logic expbit;
    exp_t e;
    cpb = (w == 0) ? 4 : 2;
    forever begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
        s = sig(w);
      end while (!(s[1] === 1'b1 && !rst));
      lastgap[w] = gap;
      if (q[w].size() == 0) begin
        chk($sformatf("spurious_frame_%0d", w), 1, 0);
        e.data = 8'h00; e.pen = 1'b0; e.pbit = 1'b0;
      end else e = q[w].pop_front();
      nb = 10 + int'(e.pen);
      len = nb * cpb;
      txerr = 0; loads = 0; shifts = 0; dones = 0; dpos = -1; busyerr = 0; overlap = 0;
      aborted = 0;
      for (int c = 0; c < len; c++) begin
        if (c != 0) @(negedge clk);
        if (rst) begin aborted = 1; break; end
        s = sig(w);
        b = c / cpb;
        if (b == 0) expbit = 1'b0;
        else if (b <= 8) expbit = e.data[b-1];
        else if (e.pen && b == 9) expbit = e.pbit;
        else expbit = 1'b1;
        if (s[2] !== expbit) txerr++;
        if (s[4]) loads++;
        if (s[3]) shifts++;
        if (s[4] && s[3]) overlap++;
        if (s[0]) begin dones++; dpos = c; end
        if (s[1] !== 1'b1) busyerr++;
      end
      if (!aborted) begin
        @(negedge clk);
        s = sig(w);
        chk($sformatf("tx_bits_%0d_%0h", w, e.data), txerr, 0);
        chk($sformatf("load_cnt_%0d", w), loads, 1);
        chk($sformatf("shift_cnt_%0d", w), shifts, 7);
        chk($sformatf("ld_sh_overlap_%0d", w), overlap, 0);
        chk($sformatf("done_cnt_%0d", w), dones, 1);
        chk($sformatf("done_pos_%0d", w), dpos, len - 1);
        chk($sformatf("busy_len_%0d", w), busyerr, 0);
        chk($sformatf("post_busy_%0d", w), s[1], 0);
        chk($sformatf("post_tx_%0d", w), s[2], 1);
        fdone[w]++;
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic push(input int w, input logic [7:0] d, input logic pe, input logic pb);
    exp_t e;
    e.data = d; e.pen = pe; e.pbit = pb;
    q[w].push_back(e);
  endtask

  task automatic send(input int w, input logic [7:0] d, input logic pe, input logic pt,
                      input logic pb);
    push(w, d, pe, pb);
    @(negedge clk);
    if (w == 0) begin din_a = d; pen_a = pe; pty_a = pt; dv_a = 1'b1; end
    else        begin din_b = d; pen_b = pe; pty_b = pt; dv_b = 1'b1; end
    @(negedge clk);
    dv_a = 1'b0;
    dv_b = 1'b0;
  endtask

  task automatic wait_frames(input int w, input int target, input string name);
    int n = 0;
    while (fdone[w] < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (fdone[w] < target) chk(name, fdone[w], target);
  endtask

  // Directed parity vectors: {data, Par_EN, Par_Type, expected parity bit}
  logic [10:0] pvec [2] = '{ {8'h07, 1'b1, 1'b0, 1'b1}, {8'h07, 1'b1, 1'b1, 1'b0} };

  initial begin
    int base, n;
    fdone[0] = 0; fdone[1] = 0;
    repeat (3) @(negedge clk);
    chk("rst_tx_a", tx_a, 1);     chk("rst_busy_a", busy_a, 0);
    chk("rst_load_a", load_a, 0); chk("rst_shift_a", shift_a, 0);
    chk("rst_done_a", done_a, 0); chk("rst_tx_b", tx_b, 1);
    chk("rst_busy_b", busy_b, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Plain frame, no parity
    send(0, 8'hA5, 1'b0, 1'b0, 1'b0);
    wait_frames(0, 1, "timeout_a5");

    // Parity frames
    for (int i = 0; i < 2; i++) begin
      send(0, pvec[i][10:3], pvec[i][2], pvec[i][1], pvec[i][0]);
      wait_frames(0, 2 + i, "timeout_parity");
    end

    // Request mid-frame must be ignored
    send(0, 8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    din_a = 8'h3C; dv_a = 1'b1;
    @(negedge clk);
    dv_a = 1'b0;
    wait_frames(0, 4, "timeout_ff");
    repeat (10) @(negedge clk);
    chk("no_extra_frame_busy", busy_a, 0);
    chk("no_extra_frame_cnt", fdone[0], 4);

    // Request held high across two frames
    push(0, 8'h55, 1'b0, 1'b0);
    push(0, 8'h55, 1'b0, 1'b0);
    @(negedge clk);
    din_a = 8'h55; pen_a = 1'b0; dv_a = 1'b1;
    wait_frames(0, 5, "timeout_hold1");
    n = 0;
    while (busy_a !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    dv_a = 1'b0;
    wait_frames(0, 6, "timeout_hold2");
    chk("b2b_idle_gap", lastgap[0], 1);

    // Reset during data bit 3 (F0: bit 3 is 0, so the line visibly rises)
    send(0, 8'hF0, 1'b0, 1'b0, 1'b0);
    repeat (16) @(negedge clk);
    chk("pre_rst_tx", tx_a, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx_a, 1);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_strobes", {load_a, shift_a, done_a}, 3'b000);
    repeat (3) @(negedge clk);
    chk("mid_rst_hold_strobes", {load_a, shift_a, done_a}, 3'b000);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    base = fdone[0];
    send(0, 8'h81, 1'b0, 1'b0, 1'b0);
    wait_frames(0, base + 1, "timeout_81");

    // Minimum bit period, even parity on zero data
    send(1, 8'h00, 1'b1, 1'b0, 1'b0);
    wait_frames(1, 1, "timeout_min");

    repeat (4) @(negedge clk);
    chk("queue_empty_a", q[0].size(), 0);
    chk("queue_empty_b", q[1].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
